// File: rtl/sfx_pkg.sv
// Shared definitions for the sound-effect voice scheduler: FSM state
// encodings, default sample/address widths and the output saturation helper.
package sfx_pkg;

  localparam int SAMPLE_W_DEF = 24;
  localparam int ADDR_W_DEF   = 15;

  // Scan FSM states, kept as plain constants so older tools can consume them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_ACC  = 3'd3;
  localparam state_t ST_OUT  = 3'd4;

  // Clamp a wide signed value into the signed range of 'width' bits.
  // The caller keeps the low 'width' bits of the result.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] value,
                                                      input int width);
    logic signed [63:0] max_val;
    logic signed [63:0] min_val;
    max_val = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_val = -(64'sd1 <<< (width - 1));
    if (value > max_val) begin
      return max_val;
    end else if (value < min_val) begin
      return min_val;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/sfx_tick_gen.sv
// Audio-rate tick generator: counts 0..TICK_DIV-1 and raises tick for the
// single cycle in which the count sits at its last value.
module sfx_tick_gen #(
  parameter int TICK_DIV = 1134
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running divider that wraps back to zero after its last value.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/sfx_voice_scheduler.sv
// Sound-effect voice scheduler: on every audio tick, walks all voices in turn,
// fetches one sample per voice from a shared ROM, sums the playing voices and
// hands the saturated mix to the codec through a valid/ready handshake.
module sfx_voice_scheduler
  import sfx_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int CLIP_LEN   = 32768,
  parameter int TICK_DIV   = 1134,
  parameter int ROM_LAT    = 2,
  parameter int GAIN_SHIFT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_VOICES-1:0] trig,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [SAMPLE_W-1:0]   rom_q,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic [NUM_VOICES-1:0] active,
  output logic                  overrun
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + GAIN_SHIFT;
  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WW    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [VW-1:0]     LAST_V    = VW'(NUM_VOICES - 1);
  localparam logic [WW-1:0]     LAST_WAIT = WW'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] CLIP_LAST = ADDR_W'(CLIP_LEN - 1);

  logic                     tick;
  state_t                   state;
  logic [VW-1:0]            v;
  logic [WW-1:0]            wait_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rom_ext;
  logic signed [63:0]       mix_wide;
  logic signed [63:0]       mix_sat;
  logic [ADDR_W-1:0]        ptr [NUM_VOICES];
  logic [NUM_VOICES-1:0]    pending;
  logic [NUM_VOICES-1:0]    pend_clr;
  logic [NUM_VOICES-1:0]    trig_r;
  logic [NUM_VOICES-1:0]    trig_prev;
  logic [NUM_VOICES-1:0]    trig_rise;

  sfx_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock  (clock),
    .reset_n(reset_n),
    .tick   (tick)
  );

  // Edge detect on the registered triggers, pending clear for the scanned
  // voice, and the sign-extended / gained / saturated datapath values.
  always_comb begin
    trig_rise = trig_r & ~trig_prev;
    pend_clr  = '0;
    if (state == ST_ADDR) begin
      pend_clr[v] = 1'b1;
    end
    rom_ext  = ACC_W'($signed(rom_q));
    mix_wide = 64'(acc) <<< GAIN_SHIFT;
    mix_sat  = sat_to_width(mix_wide, SAMPLE_W);
  end

  // Register the triggers and latch rising edges until the scan reaches the
  // voice; a new edge in the clearing cycle keeps the request alive.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      trig_r    <= '0;
      trig_prev <= '0;
      pending   <= '0;
    end else begin
      trig_r    <= trig;
      trig_prev <= trig_r;
      pending   <= (pending & ~pend_clr) | trig_rise;
    end
  end

  // Scan FSM: one ADDR/WAIT/ACC slot per voice whether or not it plays, so
  // the tick-to-sample latency never changes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      v        <= '0;
      wait_cnt <= '0;
      acc      <= '0;
      rom_addr <= '0;
      active   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        ptr[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) begin
            acc   <= '0;
            v     <= '0;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (pending[v]) begin
            ptr[v]    <= '0;
            active[v] <= 1'b1;
            rom_addr  <= '0;
          end else begin
            rom_addr <= ptr[v];
          end
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            state <= ST_ACC;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_ACC: begin
          if (active[v]) begin
            acc <= acc + rom_ext;
          end
          if (ptr[v] == CLIP_LAST) begin
            active[v] <= 1'b0;
          end else begin
            ptr[v] <= ptr[v] + ADDR_W'(1);
          end
          if (v == LAST_V) begin
            state <= ST_OUT;
          end else begin
            v     <= v + VW'(1);
            state <= ST_ADDR;
          end
        end
        ST_OUT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register and handshake: a fresh mix always overwrites the held
  // sample, flagging overrun if the previous one was never taken.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == ST_OUT) begin
        sample_out   <= mix_sat[SAMPLE_W-1:0];
        sample_valid <= 1'b1;
        overrun      <= sample_valid & ~sample_ready;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule
